alu_reservation_station: RTL and testbench
==========================================

Name: alu_reservation_station

Overview:
- Buffers dispatched arithmetic, branch and jump instructions until both source operands are available, then issues one instruction per cycle to the ALU.
- Drives the ALU's RS_* request inputs.
- Snoops the ALU and load/store result broadcasts (CDB) to wake up waiting operands.
- Sits between the decoder/dispatch stage and the ALU in the Tomasulo out-of-order core.

Parameters:
- RS_SIZE, 16, number of entries (power of two, at least 2).
- RS_WIDTH, 4, log2(RS_SIZE).
- ROB_WIDTH, 4, ROB index width; must match ROB_INDEX_RANGE in define.v.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; when low, all state holds
- roll  in  1  misprediction flush
- DP_flag  in  1  dispatch valid this cycle
- DP_op  in  6  opcode (define.v encoding)
- DP_Qj_flag  in  1  Vj not yet available
- DP_Qj  in  ROB_WIDTH  producer ROB index of Vj
- DP_Vj  in  32  Vj value when DP_Qj_flag=0
- DP_Qk_flag  in  1  Vk not yet available
- DP_Qk  in  ROB_WIDTH  producer ROB index of Vk
- DP_Vk  in  32  Vk value when DP_Qk_flag=0
- DP_imm  in  32  immediate
- DP_PC  in  32  instruction PC
- DP_ROB_idx  in  ROB_WIDTH  destination ROB entry
- ALU_flag  in  1  ALU broadcast valid
- ALU_ROB_idx  in  ROB_WIDTH  ALU broadcast tag
- ALU_val  in  32  ALU broadcast value
- LSB_flag  in  1  load broadcast valid
- LSB_ROB_idx  in  ROB_WIDTH  load broadcast tag
- LSB_val  in  32  load broadcast value
- RS_full  out  1  no free entry (combinational from current state)
- RS_flag  out  1  issue valid to ALU (registered)
- RS_op  out  6  registered
- RS_Vj  out  32  registered
- RS_Vk  out  32  registered
- RS_imm  out  32  registered
- RS_PC  out  32  registered
- RS_idx  out  ROB_WIDTH  registered

Behaviour:
- Each entry holds: busy, op, Qj_flag, Qj, Vj, Qk_flag, Qk, Vk, imm, PC, rob_idx.
- Reset, or roll while rdy is high: all busy=0 and RS_flag=0. Other registered outputs are 0 after rst and hold after roll. Roll takes priority over same-cycle dispatch, wakeup and issue.
- rdy low: no state changes. Outputs hold. Dispatch and CDB inputs are ignored.
- RS_full = all entries busy, evaluated before this edge's dispatch and issue. Dispatch must not assert DP_flag while RS_full=1. If it does, the request is dropped and no entry is corrupted.
- Dispatch (DP_flag=1, not full): write the lowest-index non-busy entry and set busy=1.
- Dispatch bypass: if DP_Qj_flag=1 and a same-cycle ALU_flag or LSB_flag tag equals DP_Qj, store the broadcast value and clear Qj_flag. Same rule for k. If both buses match the same tag, ALU wins.
- Wakeup: every busy entry with Qj_flag=1 and Qj equal to a valid broadcast tag captures the value and clears Qj_flag. Same rule for k. Both operands may wake in the same cycle from different buses.
- Select: the lowest-index entry with busy=1, Qj_flag=0 and Qk_flag=0, judged on pre-edge state.
  - Same-cycle wakeups are not visible to select.
  - A same-cycle dispatch is not visible to select.
- Issue: on the edge, load the selected entry's fields into RS_* and set RS_flag=1. The entry's busy clears on the same edge. If no entry is selected, RS_flag=0.
- Dispatch and issue in the same cycle: dispatch targets a non-busy entry, so no conflict. A slot being freed this edge is not reusable until the next cycle.
- Latency: dispatch with both operands ready at edge N gives RS_flag=1 after edge N+1. Wakeup at edge N gives the earliest issue after edge N+1.
- Throughput: 1 issue per cycle. Full occupancy with a continuous ready stream has no bubbles.
- Opcode is passed through untouched. No decoding beyond storage.

Decomposition:
- define.v holds TRUE/FALSE, ROB_INDEX_RANGE and the opcode macros (LUI..AND). Add RS_SIZE and RS_INDEX_RANGE there.
- One sub-module, rs_priority_enc (parameter N, input N-bit request vector, outputs found and lowest-set index). It is instantiated twice: free-slot search on ~busy, and ready-slot search.

Test Plan:
- Reset: rst=1 for 2 cycles -> RS_flag=0, RS_full=0. Dispatch ADD Vj=5, Vk=7, rob 3 (both ready) at edge N -> after N+1: RS_flag=1, RS_op=ADD, RS_Vj=5, RS_Vk=7, RS_idx=3; RS_flag=0 after N+2.
- Wakeup: dispatch SUB with Qj=2 pending, Vk=1, rob 4; two cycles later ALU_flag=1, ALU_ROB_idx=2, ALU_val=10 -> issue on the following edge with RS_Vj=10, RS_Vk=1, RS_idx=4. No earlier issue.
- Bypass and LSB: dispatch with Qk=6 pending in the same cycle as LSB_flag=1, LSB_ROB_idx=6, LSB_val=0xDEAD -> issues next edge with RS_Vk=0xDEAD.
- Full/order: fill 16 entries, none ready -> RS_full=1. Broadcast the tag shared by entries 5 and 9 -> entry 5 issues, then entry 9. RS_full drops after the first issue.
- Roll: 8 busy entries, ready stream in progress, assert roll together with DP_flag -> next cycle RS_flag=0, RS_full=0, the dispatched instruction is not stored, and nothing issues afterwards.
- rdy stall: ready entry present, rdy=0 for 3 cycles with ALU broadcasts active -> outputs and entries frozen, broadcasts not captured. Issue resumes one edge after rdy=1.

Source files
------------

// File: rtl/alu_reservation_station_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_reservation_station_pkg
//  Description : Shared constants for the ALU reservation station: default
//                sizing, opcode width/type and the opcode encoding table.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_reservation_station_pkg;

    localparam int c_RS_SIZE   = 16;
    localparam int c_RS_WIDTH  = 4;
    localparam int c_ROB_WIDTH = 4;
    localparam int c_OP_WIDTH  = 6;
    localparam int c_XLEN      = 32;

    typedef logic [c_OP_WIDTH-1:0] op_t;

    // Opcode encoding shared with the decoder; the station only stores these.
    localparam op_t c_OP_LUI   = 6'd1;
    localparam op_t c_OP_AUIPC = 6'd2;
    localparam op_t c_OP_JAL   = 6'd3;
    localparam op_t c_OP_JALR  = 6'd4;
    localparam op_t c_OP_BEQ   = 6'd5;
    localparam op_t c_OP_BNE   = 6'd6;
    localparam op_t c_OP_BLT   = 6'd7;
    localparam op_t c_OP_BGE   = 6'd8;
    localparam op_t c_OP_BLTU  = 6'd9;
    localparam op_t c_OP_BGEU  = 6'd10;
    localparam op_t c_OP_ADDI  = 6'd19;
    localparam op_t c_OP_SLTI  = 6'd20;
    localparam op_t c_OP_SLTIU = 6'd21;
    localparam op_t c_OP_XORI  = 6'd22;
    localparam op_t c_OP_ORI   = 6'd23;
    localparam op_t c_OP_ANDI  = 6'd24;
    localparam op_t c_OP_SLLI  = 6'd25;
    localparam op_t c_OP_SRLI  = 6'd26;
    localparam op_t c_OP_SRAI  = 6'd27;
    localparam op_t c_OP_ADD   = 6'd28;
    localparam op_t c_OP_SUB   = 6'd29;
    localparam op_t c_OP_SLL   = 6'd30;
    localparam op_t c_OP_SLT   = 6'd31;
    localparam op_t c_OP_SLTU  = 6'd32;
    localparam op_t c_OP_XOR   = 6'd33;
    localparam op_t c_OP_SRL   = 6'd34;
    localparam op_t c_OP_SRA   = 6'd35;
    localparam op_t c_OP_OR    = 6'd36;
    localparam op_t c_OP_AND   = 6'd37;

endpackage
`default_nettype wire

// File: rtl/alu_reservation_station_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_reservation_station_if
//  Description : Dispatch, CDB snoop and ALU issue bundle of the ALU
//                reservation station.
//                master : dispatch stage / CDB side (drives DP_*, ALU_*, LSB_*)
//                slave  : reservation station (drives RS_*)
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_reservation_station_if
    import alu_reservation_station_pkg::*;
#(
    parameter int ROB_WIDTH = c_ROB_WIDTH
);
    // dispatch
    logic                 DP_flag;
    op_t                  DP_op;
    logic                 DP_Qj_flag;
    logic [ROB_WIDTH-1:0] DP_Qj;
    logic [31:0]          DP_Vj;
    logic                 DP_Qk_flag;
    logic [ROB_WIDTH-1:0] DP_Qk;
    logic [31:0]          DP_Vk;
    logic [31:0]          DP_imm;
    logic [31:0]          DP_PC;
    logic [ROB_WIDTH-1:0] DP_ROB_idx;
    // result broadcasts
    logic                 ALU_flag;
    logic [ROB_WIDTH-1:0] ALU_ROB_idx;
    logic [31:0]          ALU_val;
    logic                 LSB_flag;
    logic [ROB_WIDTH-1:0] LSB_ROB_idx;
    logic [31:0]          LSB_val;
    // status / issue
    logic                 RS_full;
    logic                 RS_flag;
    op_t                  RS_op;
    logic [31:0]          RS_Vj;
    logic [31:0]          RS_Vk;
    logic [31:0]          RS_imm;
    logic [31:0]          RS_PC;
    logic [ROB_WIDTH-1:0] RS_idx;

    modport master (
        output DP_flag, DP_op, DP_Qj_flag, DP_Qj, DP_Vj, DP_Qk_flag, DP_Qk, DP_Vk,
               DP_imm, DP_PC, DP_ROB_idx,
               ALU_flag, ALU_ROB_idx, ALU_val, LSB_flag, LSB_ROB_idx, LSB_val,
        input  RS_full, RS_flag, RS_op, RS_Vj, RS_Vk, RS_imm, RS_PC, RS_idx
    );

    modport slave (
        input  DP_flag, DP_op, DP_Qj_flag, DP_Qj, DP_Vj, DP_Qk_flag, DP_Qk, DP_Vk,
               DP_imm, DP_PC, DP_ROB_idx,
               ALU_flag, ALU_ROB_idx, ALU_val, LSB_flag, LSB_ROB_idx, LSB_val,
        output RS_full, RS_flag, RS_op, RS_Vj, RS_Vk, RS_imm, RS_PC, RS_idx
    );

endinterface
`default_nettype wire

// File: rtl/alu_reservation_station_rs_priority_enc.sv
`default_nettype none
// ============================================================================
//  Module      : rs_priority_enc
//  Description : Lowest-index-first priority encoder.
//                i_req   : N-bit request vector
//                o_found : any request bit set
//                o_idx   : index of the lowest set bit (0 when none)
//  Revision    : 1.0  initial release
// ============================================================================
module rs_priority_enc #(
    parameter int N = 16,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic [N-1:0] i_req,
    output logic              o_found,
    output logic [W-1:0]      o_idx
);

    // Scan downward so the last hit written is the lowest index.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_found = 1'b1;
                o_idx   = W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_reservation_station.sv
`default_nettype none
// ============================================================================
//  Module      : alu_reservation_station
//  Description : Holds dispatched ALU/branch/jump instructions until both
//                operands are present, snoops ALU and LSB broadcasts for
//                wakeup, and issues one ready instruction per cycle.
//                clk, rst : clock, synchronous active-high reset
//                rdy      : global ready, all state holds when low
//                roll     : misprediction flush
//                rs_bus   : dispatch / CDB inputs and RS_* issue outputs
//  Revision    : 1.0  initial release
// ============================================================================
module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int RS_SIZE   = c_RS_SIZE,
    parameter int RS_WIDTH  = c_RS_WIDTH,
    parameter int ROB_WIDTH = c_ROB_WIDTH
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  rdy,
    input  wire logic                  roll,
    alu_reservation_station_if.slave   rs_bus
);

    // entry storage
    logic [RS_SIZE-1:0]   r_busy;
    logic [RS_SIZE-1:0]   r_qj_flag;
    logic [RS_SIZE-1:0]   r_qk_flag;
    op_t                  r_op     [RS_SIZE];
    logic [ROB_WIDTH-1:0] r_qj     [RS_SIZE];
    logic [ROB_WIDTH-1:0] r_qk     [RS_SIZE];
    logic [31:0]          r_vj     [RS_SIZE];
    logic [31:0]          r_vk     [RS_SIZE];
    logic [31:0]          r_imm    [RS_SIZE];
    logic [31:0]          r_pc     [RS_SIZE];
    logic [ROB_WIDTH-1:0] r_rob    [RS_SIZE];

    // issue registers
    logic                 r_rs_flag;
    op_t                  r_rs_op;
    logic [31:0]          r_rs_vj;
    logic [31:0]          r_rs_vk;
    logic [31:0]          r_rs_imm;
    logic [31:0]          r_rs_pc;
    logic [ROB_WIDTH-1:0] r_rs_idx;

    logic                 w_free_found;
    logic [RS_WIDTH-1:0]  w_free_idx;
    logic                 w_issue_found;
    logic [RS_WIDTH-1:0]  w_issue_idx;
    logic [RS_SIZE-1:0]   w_ready;
    logic                 w_dp_qj_flag;
    logic                 w_dp_qk_flag;
    logic [31:0]          w_dp_vj;
    logic [31:0]          w_dp_vk;

    assign w_ready = r_busy & ~r_qj_flag & ~r_qk_flag;

    rs_priority_enc #(.N(RS_SIZE), .W(RS_WIDTH)) u_free_enc (
        .i_req   (~r_busy),
        .o_found (w_free_found),
        .o_idx   (w_free_idx)
    );

    rs_priority_enc #(.N(RS_SIZE), .W(RS_WIDTH)) u_ready_enc (
        .i_req   (w_ready),
        .o_found (w_issue_found),
        .o_idx   (w_issue_idx)
    );

    // Operands produced on the CDB in the dispatch cycle are captured directly,
    // otherwise the entry would wait forever for a broadcast already gone.
    // The ALU bus is checked first so it wins a tag collision.
    always_comb begin
        w_dp_qj_flag = rs_bus.DP_Qj_flag;
        w_dp_vj      = rs_bus.DP_Vj;
        w_dp_qk_flag = rs_bus.DP_Qk_flag;
        w_dp_vk      = rs_bus.DP_Vk;
        if (rs_bus.DP_Qj_flag) begin
            if (rs_bus.ALU_flag && rs_bus.ALU_ROB_idx == rs_bus.DP_Qj) begin
                w_dp_qj_flag = 1'b0;
                w_dp_vj      = rs_bus.ALU_val;
            end else if (rs_bus.LSB_flag && rs_bus.LSB_ROB_idx == rs_bus.DP_Qj) begin
                w_dp_qj_flag = 1'b0;
                w_dp_vj      = rs_bus.LSB_val;
            end
        end
        if (rs_bus.DP_Qk_flag) begin
            if (rs_bus.ALU_flag && rs_bus.ALU_ROB_idx == rs_bus.DP_Qk) begin
                w_dp_qk_flag = 1'b0;
                w_dp_vk      = rs_bus.ALU_val;
            end else if (rs_bus.LSB_flag && rs_bus.LSB_ROB_idx == rs_bus.DP_Qk) begin
                w_dp_qk_flag = 1'b0;
                w_dp_vk      = rs_bus.LSB_val;
            end
        end
    end

    // Wakeup only touches busy, waiting entries; issue only touches a ready
    // entry; dispatch only touches a free entry. The three never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy    <= '0;
            r_qj_flag <= '0;
            r_qk_flag <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                r_op[i]  <= '0;
                r_qj[i]  <= '0;
                r_qk[i]  <= '0;
                r_vj[i]  <= '0;
                r_vk[i]  <= '0;
                r_imm[i] <= '0;
                r_pc[i]  <= '0;
                r_rob[i] <= '0;
            end
            r_rs_flag <= 1'b0;
            r_rs_op   <= '0;
            r_rs_vj   <= '0;
            r_rs_vk   <= '0;
            r_rs_imm  <= '0;
            r_rs_pc   <= '0;
            r_rs_idx  <= '0;
        end else if (rdy) begin
            if (roll) begin
                r_busy    <= '0;
                r_rs_flag <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (r_busy[i] && r_qj_flag[i]) begin
                        if (rs_bus.ALU_flag && rs_bus.ALU_ROB_idx == r_qj[i]) begin
                            r_qj_flag[i] <= 1'b0;
                            r_vj[i]      <= rs_bus.ALU_val;
                        end else if (rs_bus.LSB_flag && rs_bus.LSB_ROB_idx == r_qj[i]) begin
                            r_qj_flag[i] <= 1'b0;
                            r_vj[i]      <= rs_bus.LSB_val;
                        end
                    end
                    if (r_busy[i] && r_qk_flag[i]) begin
                        if (rs_bus.ALU_flag && rs_bus.ALU_ROB_idx == r_qk[i]) begin
                            r_qk_flag[i] <= 1'b0;
                            r_vk[i]      <= rs_bus.ALU_val;
                        end else if (rs_bus.LSB_flag && rs_bus.LSB_ROB_idx == r_qk[i]) begin
                            r_qk_flag[i] <= 1'b0;
                            r_vk[i]      <= rs_bus.LSB_val;
                        end
                    end
                end

                r_rs_flag <= w_issue_found;
                if (w_issue_found) begin
                    r_busy[w_issue_idx] <= 1'b0;
                    r_rs_op  <= r_op[w_issue_idx];
                    r_rs_vj  <= r_vj[w_issue_idx];
                    r_rs_vk  <= r_vk[w_issue_idx];
                    r_rs_imm <= r_imm[w_issue_idx];
                    r_rs_pc  <= r_pc[w_issue_idx];
                    r_rs_idx <= r_rob[w_issue_idx];
                end

                // No free slot means the request is dropped untouched.
                if (rs_bus.DP_flag && w_free_found) begin
                    r_busy[w_free_idx]    <= 1'b1;
                    r_op[w_free_idx]      <= rs_bus.DP_op;
                    r_qj_flag[w_free_idx] <= w_dp_qj_flag;
                    r_qj[w_free_idx]      <= rs_bus.DP_Qj;
                    r_vj[w_free_idx]      <= w_dp_vj;
                    r_qk_flag[w_free_idx] <= w_dp_qk_flag;
                    r_qk[w_free_idx]      <= rs_bus.DP_Qk;
                    r_vk[w_free_idx]      <= w_dp_vk;
                    r_imm[w_free_idx]     <= rs_bus.DP_imm;
                    r_pc[w_free_idx]      <= rs_bus.DP_PC;
                    r_rob[w_free_idx]     <= rs_bus.DP_ROB_idx;
                end
            end
        end
    end

    assign rs_bus.RS_full = ~w_free_found;
    assign rs_bus.RS_flag = r_rs_flag;
    assign rs_bus.RS_op   = r_rs_op;
    assign rs_bus.RS_Vj   = r_rs_vj;
    assign rs_bus.RS_Vk   = r_rs_vk;
    assign rs_bus.RS_imm  = r_rs_imm;
    assign rs_bus.RS_PC   = r_rs_pc;
    assign rs_bus.RS_idx  = r_rs_idx;

endmodule
`default_nettype wire

// File: tb/tb_alu_reservation_station.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_reservation_station
//  Description : Directed self-checking bench for alu_reservation_station.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_reservation_station;
    import alu_reservation_station_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic roll;
    int   total = 0;
    int   bad   = 0;

    alu_reservation_station_if #(.ROB_WIDTH(4)) bus ();

    alu_reservation_station #(.RS_SIZE(16), .RS_WIDTH(4), .ROB_WIDTH(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .rdy    (rdy),
        .roll   (roll),
        .rs_bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.DP_flag = 0; bus.DP_op = '0; bus.DP_Qj_flag = 0; bus.DP_Qj = '0;
        bus.DP_Vj = '0; bus.DP_Qk_flag = 0; bus.DP_Qk = '0; bus.DP_Vk = '0;
        bus.DP_imm = '0; bus.DP_PC = '0; bus.DP_ROB_idx = '0;
        bus.ALU_flag = 0; bus.ALU_ROB_idx = '0; bus.ALU_val = '0;
        bus.LSB_flag = 0; bus.LSB_ROB_idx = '0; bus.LSB_val = '0;
    endtask

    task automatic dp(input op_t op, input logic qjf, input logic [3:0] qj, input logic [31:0] vj,
                      input logic qkf, input logic [3:0] qk, input logic [31:0] vk,
                      input logic [3:0] rob);
        bus.DP_flag = 1; bus.DP_op = op;
        bus.DP_Qj_flag = qjf; bus.DP_Qj = qj; bus.DP_Vj = vj;
        bus.DP_Qk_flag = qkf; bus.DP_Qk = qk; bus.DP_Vk = vk;
        bus.DP_imm = 32'h100 + 32'(rob); bus.DP_PC = 32'h1000 + 32'(rob) * 4;
        bus.DP_ROB_idx = rob;
    endtask

    task automatic test_reset();
        rst = 1; rdy = 1; roll = 0; clear_inputs();
        tick(); tick();
        total++; if (bus.RS_flag !== 1'b0) begin bad++; $display("FAIL reset_flag got=%b want=0", bus.RS_flag); end
        total++; if (bus.RS_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", bus.RS_full); end
        total++; if (bus.RS_op !== 6'd0 || bus.RS_Vj !== 32'd0 || bus.RS_idx !== 4'd0)
            begin bad++; $display("FAIL reset_outs got op=%0d vj=%h idx=%0d want 0", bus.RS_op, bus.RS_Vj, bus.RS_idx); end
        rst = 0;
        tick();
    endtask

    task automatic test_issue();
        dp(c_OP_ADD, 0, 0, 32'd5, 0, 0, 32'd7, 4'd3);
        tick(); clear_inputs();
        total++; if (bus.RS_flag !== 1'b0) begin bad++; $display("FAIL issue_early got=%b want=0", bus.RS_flag); end
        tick();
        total++; if (bus.RS_flag !== 1'b1 || bus.RS_op !== c_OP_ADD || bus.RS_Vj !== 32'd5 ||
                     bus.RS_Vk !== 32'd7 || bus.RS_idx !== 4'd3 || bus.RS_imm !== 32'h103 || bus.RS_PC !== 32'h100c)
            begin bad++; $display("FAIL issue_add got flag=%b op=%0d vj=%h vk=%h idx=%0d imm=%h pc=%h want 1 %0d 5 7 3 103 100c",
                                  bus.RS_flag, bus.RS_op, bus.RS_Vj, bus.RS_Vk, bus.RS_idx, bus.RS_imm, bus.RS_PC, c_OP_ADD); end
        tick();
        total++; if (bus.RS_flag !== 1'b0) begin bad++; $display("FAIL issue_drop got=%b want=0", bus.RS_flag); end
    endtask

    task automatic test_wakeup();
        dp(c_OP_SUB, 1, 4'd2, 32'd0, 0, 0, 32'd1, 4'd4);
        tick(); clear_inputs();
        tick();
        total++; if (bus.RS_flag !== 1'b0) begin bad++; $display("FAIL wake_wait got=%b want=0", bus.RS_flag); end
        bus.ALU_flag = 1; bus.ALU_ROB_idx = 4'd2; bus.ALU_val = 32'd10;
        tick(); clear_inputs();
        total++; if (bus.RS_flag !== 1'b0) begin bad++; $display("FAIL wake_same_edge got=%b want=0", bus.RS_flag); end
        tick();
        total++; if (bus.RS_flag !== 1'b1 || bus.RS_op !== c_OP_SUB || bus.RS_Vj !== 32'd10 ||
                     bus.RS_Vk !== 32'd1 || bus.RS_idx !== 4'd4)
            begin bad++; $display("FAIL wake_issue got flag=%b vj=%h vk=%h idx=%0d want 1 a 1 4",
                                  bus.RS_flag, bus.RS_Vj, bus.RS_Vk, bus.RS_idx); end
        tick();
        total++; if (bus.RS_flag !== 1'b0) begin bad++; $display("FAIL wake_after got=%b want=0", bus.RS_flag); end
    endtask

    task automatic test_bypass();
        dp(c_OP_AND, 0, 0, 32'd3, 1, 4'd6, 32'd0, 4'd5);
        bus.LSB_flag = 1; bus.LSB_ROB_idx = 4'd6; bus.LSB_val = 32'hDEAD;
        tick(); clear_inputs();
        total++; if (bus.RS_flag !== 1'b0) begin bad++; $display("FAIL byp_early got=%b want=0", bus.RS_flag); end
        // both buses carry tag 7: the ALU value must be kept
        dp(c_OP_OR, 1, 4'd7, 32'd0, 0, 0, 32'd0, 4'd8);
        bus.ALU_flag = 1; bus.ALU_ROB_idx = 4'd7; bus.ALU_val = 32'h11;
        bus.LSB_flag = 1; bus.LSB_ROB_idx = 4'd7; bus.LSB_val = 32'h22;
        tick(); clear_inputs();
        total++; if (bus.RS_flag !== 1'b1 || bus.RS_Vj !== 32'd3 || bus.RS_Vk !== 32'hDEAD || bus.RS_idx !== 4'd5)
            begin bad++; $display("FAIL byp_lsb got flag=%b vj=%h vk=%h idx=%0d want 1 3 dead 5",
                                  bus.RS_flag, bus.RS_Vj, bus.RS_Vk, bus.RS_idx); end
        tick();
        total++; if (bus.RS_flag !== 1'b1 || bus.RS_Vj !== 32'h11 || bus.RS_idx !== 4'd8 || bus.RS_op !== c_OP_OR)
            begin bad++; $display("FAIL byp_alu_wins got flag=%b vj=%h idx=%0d want 1 11 8",
                                  bus.RS_flag, bus.RS_Vj, bus.RS_idx); end
        tick();
    endtask

    task automatic test_full_order();
        for (int i = 0; i < 16; i++) begin
            dp(c_OP_ADDI, 1, (i == 5 || i == 9) ? 4'd1 : 4'd0, 32'd0, 0, 0, 32'(i), 4'(i));
            tick();
        end
        clear_inputs();
        total++; if (bus.RS_full !== 1'b1) begin bad++; $display("FAIL full_set got=%b want=1", bus.RS_full); end
        // request while full: must be dropped
        dp(c_OP_ADD, 0, 0, 32'd1, 0, 0, 32'd1, 4'd15);
        tick(); clear_inputs();
        bus.ALU_flag = 1; bus.ALU_ROB_idx = 4'd1; bus.ALU_val = 32'h55;
        tick(); clear_inputs();
        total++; if (bus.RS_flag !== 1'b0 || bus.RS_full !== 1'b1)
            begin bad++; $display("FAIL full_wait got flag=%b full=%b want 0 1", bus.RS_flag, bus.RS_full); end
        tick();
        total++; if (bus.RS_flag !== 1'b1 || bus.RS_idx !== 4'd5 || bus.RS_Vj !== 32'h55 || bus.RS_Vk !== 32'd5)
            begin bad++; $display("FAIL order_first got flag=%b idx=%0d vj=%h vk=%h want 1 5 55 5",
                                  bus.RS_flag, bus.RS_idx, bus.RS_Vj, bus.RS_Vk); end
        total++; if (bus.RS_full !== 1'b0) begin bad++; $display("FAIL full_drop got=%b want=0", bus.RS_full); end
        tick();
        total++; if (bus.RS_flag !== 1'b1 || bus.RS_idx !== 4'd9 || bus.RS_Vk !== 32'd9)
            begin bad++; $display("FAIL order_second got flag=%b idx=%0d vk=%h want 1 9 9",
                                  bus.RS_flag, bus.RS_idx, bus.RS_Vk); end
        tick();
        total++; if (bus.RS_flag !== 1'b0) begin bad++; $display("FAIL full_no_extra got=%b idx=%0d want=0", bus.RS_flag, bus.RS_idx); end
    endtask

    task automatic test_roll();
        roll = 1; tick(); roll = 0;
        total++; if (bus.RS_full !== 1'b0) begin bad++; $display("FAIL roll_clear got=%b want=0", bus.RS_full); end
        for (int i = 0; i < 8; i++) begin
            dp(c_OP_XOR, 1, 4'd3, 32'd0, 0, 0, 32'(i), 4'(i));
            tick();
        end
        clear_inputs();
        bus.ALU_flag = 1; bus.ALU_ROB_idx = 4'd3; bus.ALU_val = 32'h33;
        tick(); clear_inputs();
        tick();
        total++; if (bus.RS_flag !== 1'b1 || bus.RS_idx !== 4'd0) begin bad++; $display("FAIL roll_stream0 got flag=%b idx=%0d want 1 0", bus.RS_flag, bus.RS_idx); end
        tick();
        total++; if (bus.RS_flag !== 1'b1 || bus.RS_idx !== 4'd1) begin bad++; $display("FAIL roll_stream1 got flag=%b idx=%0d want 1 1", bus.RS_flag, bus.RS_idx); end
        roll = 1;
        dp(c_OP_ADD, 0, 0, 32'd1, 0, 0, 32'd2, 4'd12);
        tick(); roll = 0; clear_inputs();
        total++; if (bus.RS_flag !== 1'b0 || bus.RS_full !== 1'b0)
            begin bad++; $display("FAIL roll_now got flag=%b full=%b want 0 0", bus.RS_flag, bus.RS_full); end
        total++; if (bus.RS_idx !== 4'd1) begin bad++; $display("FAIL roll_hold_idx got=%0d want=1", bus.RS_idx); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (bus.RS_flag !== 1'b0) begin bad++; $display("FAIL roll_after got flag=%b idx=%0d want 0", bus.RS_flag, bus.RS_idx); end
        end
    endtask

    task automatic test_rdy_stall();
        dp(c_OP_SLT, 1, 4'd4, 32'd0, 0, 0, 32'd0, 4'd13);
        tick();
        dp(c_OP_ADD, 0, 0, 32'd9, 0, 0, 32'd2, 4'd10);
        tick();
        dp(c_OP_SLL, 0, 0, 32'd6, 0, 0, 32'd1, 4'd12);
        tick();
        total++; if (bus.RS_flag !== 1'b1 || bus.RS_idx !== 4'd10) begin bad++; $display("FAIL stall_pre got flag=%b idx=%0d want 1 10", bus.RS_flag, bus.RS_idx); end
        rdy = 0;
        dp(c_OP_ADD, 0, 0, 32'd4, 0, 0, 32'd4, 4'd14);
        bus.ALU_flag = 1; bus.ALU_ROB_idx = 4'd4; bus.ALU_val = 32'h77;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (bus.RS_flag !== 1'b1 || bus.RS_idx !== 4'd10 || bus.RS_Vj !== 32'd9)
                begin bad++; $display("FAIL stall_hold got flag=%b idx=%0d vj=%h want 1 10 9", bus.RS_flag, bus.RS_idx, bus.RS_Vj); end
        end
        rdy = 1; clear_inputs();
        tick();
        total++; if (bus.RS_flag !== 1'b1 || bus.RS_idx !== 4'd12) begin bad++; $display("FAIL stall_resume got flag=%b idx=%0d want 1 12", bus.RS_flag, bus.RS_idx); end
        tick();
        total++; if (bus.RS_flag !== 1'b0) begin bad++; $display("FAIL stall_ignored got flag=%b idx=%0d want 0", bus.RS_flag, bus.RS_idx); end
        bus.ALU_flag = 1; bus.ALU_ROB_idx = 4'd4; bus.ALU_val = 32'h99;
        tick(); clear_inputs();
        tick();
        total++; if (bus.RS_flag !== 1'b1 || bus.RS_idx !== 4'd13 || bus.RS_Vj !== 32'h99)
            begin bad++; $display("FAIL stall_late_wake got flag=%b idx=%0d vj=%h want 1 13 99", bus.RS_flag, bus.RS_idx, bus.RS_Vj); end
        tick();
    endtask

    initial begin
        test_reset();
        test_issue();
        test_wakeup();
        test_bypass();
        test_full_order();
        test_roll();
        test_rdy_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
